lcd_nibble_writer: RTL

LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

---
 rtl/lcd_nibble_writer_if.sv | 22 ++
 rtl/lcd_nibble_writer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer_if.sv
// CPU-side write port of the LCD nibble writer.
//   master (CPU decode) drives: wr_req, wr_rs, wr_data, clr_ovf
//   slave  (writer)     drives: busy, full, overflow
interface lcd_nibble_writer_if;
  logic       wr_req;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       busy;
  logic       full;
  logic       overflow;

  modport master (
    output wr_req, wr_rs, wr_data, clr_ovf,
    input  busy, full, overflow
  );

  modport slave (
    input  wr_req, wr_rs, wr_data, clr_ovf,
    output busy, full, overflow
  );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Queues CPU byte writes in a 4-deep FIFO and plays each byte out to an
// HD44780-compatible LCD in 4-bit mode: high nibble then low nibble, each
// with address setup, enable pulse and hold, followed by a command/data
// execution wait (long wait for clear/home commands).
// Ports:
//   sys_clk, rst_n    clock, asynchronous active-low reset
//   cpu (slave)       write strobe/rs/data, overflow clear; busy/full/overflow
//   lcd_e/rw/rs/db    LCD strobe, read/write (always write), register select,
//                     data bus DB7..DB4
module lcd_nibble_writer #(
  parameter int unsigned T_AS   = 2,
  parameter int unsigned T_PW   = 4,
  parameter int unsigned T_H    = 2,
  parameter int unsigned T_EXEC = 20,
  parameter int unsigned T_LONG = 100
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  lcd_nibble_writer_if.slave  cpu,
  output logic                lcd_e,
  output logic                lcd_rw,
  output logic                lcd_rs,
  output logic [3:0]          lcd_db
);

  localparam int unsigned T_M1  = (T_AS > T_PW)   ? T_AS : T_PW;
  localparam int unsigned T_M2  = (T_M1 > T_H)    ? T_M1 : T_H;
  localparam int unsigned T_M3  = (T_M2 > T_EXEC) ? T_M2 : T_EXEC;
  localparam int unsigned T_MAX = (T_M3 > T_LONG) ? T_M3 : T_LONG;
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);
  localparam int unsigned ENT_W = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned OCC_W = 3;

  typedef enum logic [2:0] {
    IDLE, SET_H, PUL_H, HLD_H, SET_L, PUL_L, HLD_L, EXEC
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   hold_q, hold_d;
  logic [ENT_W-1:0]   fifo_q [DEPTH];
  logic [ENT_W-1:0]   fifo_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               full_q, full_d;
  logic               lcd_e_q, lcd_e_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic [3:0]         lcd_db_q, lcd_db_d;
  logic               pop, push, drop, last;

  // Clear-display (0x01) and return-home (0x02) commands need the long wait.
  function automatic logic is_long(input logic [ENT_W-1:0] ent);
    return !ent[8] && ((ent[7:0] == 8'h01) || (ent[7:0] == 8'h02));
  endfunction

  // Sequencer: one down-counter times every state, state advances at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    // a zero-length parameter still advances after one cycle
    last    = (cnt_q <= CNT_W'(1));
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = fifo_q[rd_ptr_q];
          state_d = SET_H;
          cnt_d   = CNT_W'(T_AS);
        end
      end
      SET_H: if (last) begin state_d = PUL_H; cnt_d = CNT_W'(T_PW); end
             else cnt_d = cnt_q - CNT_W'(1);
      PUL_H: if (last) begin state_d = HLD_H; cnt_d = CNT_W'(T_H); end
             else cnt_d = cnt_q - CNT_W'(1);
      HLD_H: if (last) begin state_d = SET_L; cnt_d = CNT_W'(T_AS); end
             else cnt_d = cnt_q - CNT_W'(1);
      SET_L: if (last) begin state_d = PUL_L; cnt_d = CNT_W'(T_PW); end
             else cnt_d = cnt_q - CNT_W'(1);
      PUL_L: if (last) begin state_d = HLD_L; cnt_d = CNT_W'(T_H); end
             else cnt_d = cnt_q - CNT_W'(1);
      HLD_L: if (last) begin
               state_d = EXEC;
               cnt_d   = is_long(hold_q) ? CNT_W'(T_LONG) : CNT_W'(T_EXEC);
             end else cnt_d = cnt_q - CNT_W'(1);
      EXEC:  if (last) begin state_d = IDLE; cnt_d = '0; end
             else cnt_d = cnt_q - CNT_W'(1);
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  // FIFO: a write while full is still taken when the head pops that cycle.
  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = cpu.wr_req && ((count_q != OCC_W'(DEPTH)) || pop);
    drop       = cpu.wr_req && !push;
    if (push) begin
      fifo_d[wr_ptr_q] = {cpu.wr_rs, cpu.wr_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d    = count_q + OCC_W'(push) - OCC_W'(pop);
    // a drop in the same cycle as clr_ovf keeps the flag set
    overflow_d = drop ? 1'b1 : (cpu.clr_ovf ? 1'b0 : overflow_q);
  end

  // Registered outputs, computed from the next state so they line up with it.
  always_comb begin
    lcd_e_d  = (state_d == PUL_H) || (state_d == PUL_L);
    lcd_rs_d = lcd_rs_q;
    lcd_db_d = lcd_db_q;
    case (state_d)
      SET_H, PUL_H, HLD_H: begin lcd_rs_d = hold_d[8]; lcd_db_d = hold_d[7:4]; end
      SET_L, PUL_L, HLD_L: begin lcd_rs_d = hold_d[8]; lcd_db_d = hold_d[3:0]; end
      default: ;
    endcase
    busy_d = (count_d != '0) || (state_d != IDLE);
    full_d = (count_d == OCC_W'(DEPTH));
  end

  // State, FIFO and output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_db_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_db_q   <= lcd_db_d;
    end
  end

  assign cpu.busy     = busy_q;
  assign cpu.full     = full_q;
  assign cpu.overflow = overflow_q;
  assign lcd_e        = lcd_e_q;
  assign lcd_rw       = 1'b0;
  assign lcd_rs       = lcd_rs_q;
  assign lcd_db       = lcd_db_q;

endmodule
